spi_reg_access: RTL and testbench

Register-access sequencer that sits directly in front of spi_master. It turns one register read/write command into an SPI byte frame on spi_master's MOSI AXIS sink and collects the full-duplex MISO bytes from spi_master's AXIS source. It returns one response per command: read data plus an error flag. It gives software-facing logic a single-handshake register port with no byte-level knowledge.

---
 rtl/spi_reg_access_pkg.sv | 38 +++
 rtl/spi_reg_access_if.sv | 22 ++
 rtl/spi_reg_access.sv | 178 +++++++++++++++++
 tb/tb_spi_reg_access.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_access_pkg.sv
// Shared types, widths and helpers for the SPI register-access sequencer.
package spi_reg_access_pkg;

    localparam int unsigned TRANSFER_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH     = TRANSFER_WIDTH - 1;
    localparam int unsigned DATA_WORDS     = 2;
    localparam int unsigned LEN_WIDTH      = $clog2(DATA_WORDS + 1);
    localparam int unsigned CNT_WIDTH      = $clog2(DATA_WORDS + 2);
    localparam int unsigned RDATA_WIDTH    = DATA_WORDS * TRANSFER_WIDTH;

    localparam logic RW_READ = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    // Header word: read/write flag in the MSB, register address below it.
    function automatic logic [TRANSFER_WIDTH-1:0] make_header(
        input logic                  rw,
        input logic [ADDR_WIDTH-1:0] addr
    );
        return {rw, addr};
    endfunction

    // Zero length means one word; anything above the capacity is capped.
    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
        if (len == '0) begin
            return LEN_WIDTH'(1);
        end
        if (32'(len) > DATA_WORDS) begin
            return LEN_WIDTH'(DATA_WORDS);
        end
        return len;
    endfunction

endpackage

// File: rtl/spi_reg_access_if.sv
// AXI-stream bundle shared with spi_master.
interface axis_interface #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH = 1,
    parameter int unsigned USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport Source (output tdata, tvalid, tlast, tkeep, tid, tdest, tuser, input tready);
    modport Sink   (input tdata, tvalid, tlast, tkeep, tid, tdest, tuser, output tready);
    modport master (output tdata, tvalid, tlast, tkeep, tid, tdest, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tkeep, tid, tdest, tuser, output tready);
endinterface

// File: rtl/spi_reg_access.sv
// Turns one register command into an SPI word frame and returns one response.
module spi_reg_access
    import spi_reg_access_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_read,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    input  logic [RDATA_WIDTH-1:0] cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [RDATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_error,
    output logic                   busy,
    axis_interface.Source          mosi_stream,
    axis_interface.Sink            miso_stream
);

    state_t                    state_q, state_d;
    logic [LEN_WIDTH-1:0]      len_q;
    logic [CNT_WIDTH-1:0]      frame_n_q;
    logic                      read_q;
    logic [RDATA_WIDTH-1:0]    wdata_q;
    logic [CNT_WIDTH-1:0]      tx_cnt_q, rx_cnt_q;
    logic [RDATA_WIDTH-1:0]    acc_q;
    logic                      err_q;
    logic                      tvalid_q, tlast_q;
    logic [TRANSFER_WIDTH-1:0] tdata_q;
    logic [RDATA_WIDTH-1:0]    rdata_q;
    logic                      error_q;

    logic                      cmd_fire_c, rsp_fire_c, mosi_fire_c, miso_fire_c;
    logic [CNT_WIDTH-1:0]      tx_next_c, word_idx_c, rx_last_c;
    logic [TRANSFER_WIDTH-1:0] tx_word_c;
    logic                      unused_miso;

    assign cmd_fire_c  = cmd_valid && cmd_ready;
    assign rsp_fire_c  = rsp_valid && rsp_ready;
    assign mosi_fire_c = mosi_stream.tvalid && mosi_stream.tready;
    assign miso_fire_c = miso_stream.tvalid && miso_stream.tready;
    assign tx_next_c   = tx_cnt_q + CNT_WIDTH'(1);
    assign word_idx_c  = CNT_WIDTH'(len_q) - tx_next_c;
    assign rx_last_c   = frame_n_q - CNT_WIDTH'(1);
    assign unused_miso = ^{miso_stream.tkeep, miso_stream.tid, miso_stream.tdest, miso_stream.tuser};

    assign mosi_stream.tvalid = tvalid_q;
    assign mosi_stream.tdata  = tdata_q;
    assign mosi_stream.tlast  = tlast_q;
    assign mosi_stream.tkeep  = '1;
    assign mosi_stream.tid    = '0;
    assign mosi_stream.tdest  = '0;
    assign mosi_stream.tuser  = '0;
    assign rsp_rdata          = rdata_q;
    assign rsp_error          = error_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire_c) state_d = XFER;
            XFER:    if (tx_cnt_q == frame_n_q && rx_cnt_q == frame_n_q) state_d = RESP;
            RESP:    if (rsp_fire_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs; miso is paused only while a response is pending.
    always_comb begin
        cmd_ready          = 1'b0;
        rsp_valid          = 1'b0;
        busy               = 1'b1;
        miso_stream.tready = 1'b1;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            RESP: begin
                rsp_valid          = 1'b1;
                miso_stream.tready = 1'b0;
            end
            default: ;
        endcase
    end

    // Next outgoing data word: write data MSB word first, zeros for reads.
    always_comb begin
        tx_word_c = '0;
        for (int unsigned i = 0; i < DATA_WORDS; i++) begin
            if (CNT_WIDTH'(i) == word_idx_c) tx_word_c = wdata_q[i*TRANSFER_WIDTH +: TRANSFER_WIDTH];
        end
        if (read_q) tx_word_c = '0;
    end

    // Command latch at accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q     <= '0;
            frame_n_q <= '0;
            read_q    <= 1'b0;
            wdata_q   <= '0;
        end else if (cmd_fire_c) begin
            len_q     <= clamp_len(cmd_len);
            frame_n_q <= CNT_WIDTH'(clamp_len(cmd_len)) + CNT_WIDTH'(1);
            read_q    <= cmd_read;
            wdata_q   <= cmd_wdata;
        end
    end

    // MOSI side: header on accept, then one word per handshake, held while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tx_cnt_q <= '0;
        end else if (cmd_fire_c) begin
            tvalid_q <= 1'b1;
            tdata_q  <= make_header(cmd_read, cmd_addr);
            tlast_q  <= 1'b0;
            tx_cnt_q <= '0;
        end else if (state_q == XFER && mosi_fire_c) begin
            tx_cnt_q <= tx_next_c;
            if (tx_next_c < frame_n_q) begin
                tvalid_q <= 1'b1;
                tdata_q  <= tx_word_c;
                tlast_q  <= (tx_next_c == rx_last_c);
            end else begin
                tvalid_q <= 1'b0;
                tdata_q  <= '0;
                tlast_q  <= 1'b0;
            end
        end
    end

    // MISO side: drop the header echo, shift read data in, flag tlast misplacement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_cnt_q <= '0;
            acc_q    <= '0;
            err_q    <= 1'b0;
        end else if (cmd_fire_c) begin
            rx_cnt_q <= '0;
            acc_q    <= '0;
            err_q    <= 1'b0;
        end else if (state_q == XFER && miso_fire_c && rx_cnt_q < frame_n_q) begin
            rx_cnt_q <= rx_cnt_q + CNT_WIDTH'(1);
            if (rx_cnt_q != '0 && read_q) begin
                acc_q <= (acc_q << TRANSFER_WIDTH) | RDATA_WIDTH'(miso_stream.tdata);
            end
            if (miso_stream.tlast != (rx_cnt_q == rx_last_c)) err_q <= 1'b1;
        end
    end

    // Response payload captured on entry to RESP, cleared after handoff.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            error_q <= 1'b0;
        end else if (state_q == XFER && state_d == RESP) begin
            rdata_q <= read_q ? acc_q : '0;
            error_q <= err_q;
        end else if (rsp_fire_c) begin
            rdata_q <= '0;
            error_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_reg_access.sv
// Scoreboard bench for spi_reg_access with a scripted spi_master model.
module tb_spi_reg_access;
    import spi_reg_access_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [6:0]  cmd_addr;
    logic [1:0]  cmd_len;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_error, busy;
    logic [15:0] rsp_rdata;

    axis_interface #(.DATA_WIDTH(TRANSFER_WIDTH)) mosi ();
    axis_interface #(.DATA_WIDTH(TRANSFER_WIDTH)) miso ();

    spi_reg_access dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_read   (cmd_read),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .busy       (busy),
        .mosi_stream(mosi),
        .miso_stream(miso)
    );

    always #5 clk = ~clk;

    beat_t exp_mosi[$];
    beat_t miso_q[$];
    rsp_t  exp_rsp[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    mosi_beats = 0;
    logic  toggle_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"},  32'(cmd_ready), 32'd1);
        check({tag, "_rsp_valid"},  32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"},  32'(rsp_rdata), 32'd0);
        check({tag, "_rsp_error"},  32'(rsp_error), 32'd0);
        check({tag, "_busy"},       32'(busy), 32'd0);
        check({tag, "_mosi_valid"}, 32'(mosi.tvalid), 32'd0);
        check({tag, "_mosi_data"},  32'(mosi.tdata), 32'd0);
        check({tag, "_mosi_last"},  32'(mosi.tlast), 32'd0);
        check({tag, "_mosi_keep"},  32'(mosi.tkeep), 32'd1);
        check({tag, "_miso_ready"}, 32'(miso.tready), 32'd1);
    endtask

    // Issue one command; expected mosi words, miso script and response are queued at accept.
    task automatic do_cmd(input logic rd, input logic [6:0] addr, input logic [1:0] len,
                          input logic [15:0] wdata, input logic [7:0] m0, input logic [7:0] m1,
                          input logic [7:0] m2, input logic [2:0] mlast,
                          input logic [15:0] exp_rdata, input logic exp_err);
        int         l;
        logic [7:0] m[3];
        logic [7:0] w;
        bit         accepted;
        l = (len == 2'd0) ? 1 : ((len > 2'd2) ? 2 : int'(len));
        m[0] = m0; m[1] = m1; m[2] = m2;
        cmd_read  = rd;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        accepted  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        check("cmd_accept", 32'(accepted), 32'd1);
        exp_mosi.push_back(beat_t'{data: {rd, addr}, last: 1'b0});
        for (int k = 1; k <= l; k++) begin
            w = rd ? 8'h00 : 8'(wdata >> ((l - k) * 8));
            exp_mosi.push_back(beat_t'{data: w, last: (k == l)});
        end
        for (int k = 0; k <= l; k++) miso_q.push_back(beat_t'{data: m[k], last: mlast[k]});
        exp_rsp.push_back(rsp_t'{rdata: exp_rdata, err: exp_err});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_mosi.size() == 0 && exp_rsp.size() == 0 && !busy) break;
        end
        check({tag, "_mosi_drained"}, 32'(exp_mosi.size()), 32'd0);
        check({tag, "_rsp_drained"},  32'(exp_rsp.size()), 32'd0);
        check({tag, "_idle"},         32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor at negedge, drive spi_master-side stimulus just after posedge.
    initial begin : monitor_driver
        logic       stall_prev;
        logic [7:0] stall_data;
        logic       stall_last;
        logic       miso_hs;
        beat_t      b;
        rsp_t       r;
        stall_prev  = 1'b0;
        stall_data  = '0;
        stall_last  = 1'b0;
        miso_hs     = 1'b0;
        mosi.tready = 1'b1;
        miso.tvalid = 1'b0;
        miso.tdata  = '0;
        miso.tlast  = 1'b0;
        miso.tkeep  = '1;
        miso.tid    = '0;
        miso.tdest  = '0;
        miso.tuser  = '0;
        forever begin
            @(negedge clk);
            miso_hs = 1'b0;
            if (reset) begin
                if (stall_prev) begin
                    check("mosi_hold_valid", 32'(mosi.tvalid), 32'd1);
                    check("mosi_hold_data",  32'(mosi.tdata), 32'(stall_data));
                    check("mosi_hold_last",  32'(mosi.tlast), 32'(stall_last));
                end
                if (mosi.tvalid && mosi.tready) begin
                    mosi_beats++;
                    if (exp_mosi.size() == 0) begin
                        check("mosi_extra_word", 32'(mosi.tdata) | 32'h100, 32'd0);
                    end else begin
                        b = exp_mosi.pop_front();
                        check("mosi_data", 32'(mosi.tdata), 32'(b.data));
                        check("mosi_last", 32'(mosi.tlast), 32'(b.last));
                    end
                end
                stall_prev = mosi.tvalid && !mosi.tready;
                stall_data = mosi.tdata;
                stall_last = mosi.tlast;
                miso_hs    = miso.tvalid && miso.tready;
                if (rsp_valid && rsp_ready) begin
                    if (exp_rsp.size() == 0) begin
                        check("rsp_extra", 32'(rsp_rdata) | 32'h10000, 32'd0);
                    end else begin
                        r = exp_rsp.pop_front();
                        check("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
                        check("rsp_error", 32'(rsp_error), 32'(r.err));
                    end
                end
            end else begin
                stall_prev = 1'b0;
            end
            @(posedge clk);
            #1;
            if (miso_hs && miso_q.size() > 0) void'(miso_q.pop_front());
            if (miso_q.size() > 0) begin
                miso.tvalid = 1'b1;
                miso.tdata  = miso_q[0].data;
                miso.tlast  = miso_q[0].last;
            end else begin
                miso.tvalid = 1'b0;
                miso.tdata  = '0;
                miso.tlast  = 1'b0;
            end
            mosi.tready = toggle_mode ? ~mosi.tready : 1'b1;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit seen;
        int start_beats;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_read  = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("por");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Write, len 2.
        do_cmd(1'b0, 7'h12, 2'd2, 16'hBEEF, 8'hFF, 8'h00, 8'h00, 3'b100, 16'h0000, 1'b0);
        wait_done("wr2");

        // Read, len 2.
        do_cmd(RW_READ, 7'h05, 2'd2, 16'h0000, 8'hFF, 8'hA5, 8'h3C, 3'b100, 16'hA53C, 1'b0);
        wait_done("rd2");

        // Same read with mosi backpressure every other cycle.
        toggle_mode = 1'b1;
        do_cmd(RW_READ, 7'h05, 2'd2, 16'h0000, 8'hFF, 8'hA5, 8'h3C, 3'b100, 16'hA53C, 1'b0);
        wait_done("rd2_stall");
        toggle_mode = 1'b0;

        // Early miso tlast: framing error.
        do_cmd(RW_READ, 7'h22, 2'd2, 16'h0000, 8'hFF, 8'h11, 8'h22, 3'b010, 16'h1122, 1'b1);
        wait_done("rd_err");

        // Stray miso beat while idle must be dropped without side effects.
        miso_q.push_back(beat_t'{data: 8'hEE, last: 1'b1});
        repeat (4) @(posedge clk);
        #1;

        // Clean write clears the error.
        do_cmd(1'b0, 7'h30, 2'd1, 16'h0077, 8'h00, 8'h00, 8'h00, 3'b010, 16'h0000, 1'b0);
        wait_done("wr1");

        // Oversized length clamps to two words.
        do_cmd(1'b0, 7'h40, 2'd3, 16'h1234, 8'h00, 8'h00, 8'h00, 3'b100, 16'h0000, 1'b0);
        wait_done("wr_clamp");

        // Response backpressure: payload stable, new command refused.
        rsp_ready = 1'b0;
        do_cmd(RW_READ, 7'h7F, 2'd1, 16'h0000, 8'hAA, 8'h5A, 8'h00, 3'b010, 16'h005A, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("hold_rsp_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        cmd_read  = 1'b0;
        cmd_addr  = 7'h55;
        cmd_len   = 2'd1;
        cmd_wdata = 16'h00AB;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_rdata", 32'(rsp_rdata), 32'h005A);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_mosi_idle", 32'(mosi.tvalid), 32'd0);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_cmd_ready", 32'(cmd_ready), 32'd1);
        check("release_rsp_valid", 32'(rsp_valid), 32'd0);
        wait_done("hold");

        // Reset in the middle of a write frame.
        start_beats = mosi_beats;
        do_cmd(1'b0, 7'h12, 2'd2, 16'hBEEF, 8'hFF, 8'h00, 8'h00, 3'b100, 16'h0000, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mosi_beats > start_beats) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid_first_beat", 32'(seen), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_vals("mid");
        exp_mosi.delete();
        exp_rsp.delete();
        miso_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Post-reset read with zero length sends header plus one dummy word.
        do_cmd(RW_READ, 7'h01, 2'd0, 16'h0000, 8'h00, 8'h99, 8'h00, 3'b010, 16'h0099, 1'b0);
        wait_done("rd_len0");
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
